// File: rtl/barrel_shifter_pkg.sv
// Shared types for the pipelined barrel shifter: operation codes and the
// width-independent control part of each stage payload.
package barrel_shifter_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    SLL = 3'd0,
    SRL = 3'd1,
    SRA = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } shift_op_e;

  // Op is kept raw so reserved codes 5..7 travel through the pipe untouched.
  typedef struct packed {
    logic            valid;
    logic [OP_W-1:0] op;
  } stage_ctrl_t;

endpackage

// File: rtl/barrel_shift_stage.sv
// One pipeline stage: conditionally moves data by 2**STAGE_IDX according to
// the matching amount bit, then registers the whole payload under advance.
module barrel_shift_stage
  import barrel_shifter_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SHW       = 3,
  parameter int unsigned STAGE_IDX = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  input  logic [SHW-1:0]   d_amount,
  input  logic [OP_W-1:0]  d_op,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data,
  output logic [SHW-1:0]   q_amount,
  output logic [OP_W-1:0]  q_op
);

  localparam int unsigned DIST = 1 << STAGE_IDX;

  typedef struct packed {
    stage_ctrl_t      ctrl;
    logic [SHW-1:0]   amount;
    logic [WIDTH-1:0] data;
  } stage_t;

  logic [WIDTH-1:0] moved;
  stage_t           r;

  // SRA fills from the stage-input MSB, which is still the original sign.
  always_comb begin
    moved = d_data;
    if (d_amount[STAGE_IDX]) begin
      case (d_op)
        SLL:     moved = d_data << DIST;
        SRL:     moved = d_data >> DIST;
        SRA:     moved = {{DIST{d_data[WIDTH-1]}}, d_data[WIDTH-1:DIST]};
        ROL:     moved = {d_data[WIDTH-1-DIST:0], d_data[WIDTH-1:WIDTH-DIST]};
        ROR:     moved = {d_data[DIST-1:0], d_data[WIDTH-1:DIST]};
        default: moved = d_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
    end else if (advance) begin
      r <= '{ctrl: '{valid: d_valid, op: d_op}, amount: d_amount, data: moved};
    end
  end

  assign q_valid  = r.ctrl.valid;
  assign q_op     = r.ctrl.op;
  assign q_amount = r.amount;
  assign q_data   = r.data;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: SHW registered stages, one per amount bit, with a
// global stall driven by downstream backpressure.
module barrel_shifter_pipe
  import barrel_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amount,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("barrel_shifter_pipe: WIDTH must be a power of two and at least 2");
  end
  if (SHW != $clog2(WIDTH)) begin : g_bad_shw
    $error("barrel_shifter_pipe: SHW must equal clog2(WIDTH)");
  end

  // Index 0 is the input port; index i+1 is the register of stage i.
  logic [SHW:0]                valid;
  logic [SHW:0][WIDTH-1:0]     data;
  logic [SHW:0][SHW-1:0]       amount;
  logic [SHW:0][OP_W-1:0]      op;
  logic                        advance;
  logic                        unused_tail;

  assign advance   = !valid[SHW] || out_ready;
  assign in_ready  = advance;

  assign valid[0]  = in_valid && advance;
  assign data[0]   = in_data;
  assign amount[0] = in_amount;
  assign op[0]     = in_op;

  for (genvar i = 0; i < SHW; i++) begin : g_stage
    barrel_shift_stage #(
      .WIDTH    (WIDTH),
      .SHW      (SHW),
      .STAGE_IDX(i)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .advance (advance),
      .d_valid (valid[i]),
      .d_data  (data[i]),
      .d_amount(amount[i]),
      .d_op    (op[i]),
      .q_valid (valid[i+1]),
      .q_data  (data[i+1]),
      .q_amount(amount[i+1]),
      .q_op    (op[i+1])
    );
  end

  assign out_valid = valid[SHW];
  assign out_data  = data[SHW];
  assign out_zero  = (data[SHW] == '0);

  // Amount and op are fully consumed by the last stage.
  assign unused_tail = ^{amount[SHW], op[SHW]};

endmodule
